gate_check_sequencer: RTL
=========================

# gate_check_sequencer

Self-checking vector sequencer that sits directly upstream and downstream of the NAND-built gate cells. It drives the shared two-bit input pair (`in1`, `in2`) through all four combinations in Gray order. After a settle window it compares up to N_CHECK gate-under-test outputs against their primitive-gate reference outputs and accumulates a pass/fail verdict. It replaces free-running `#delay` stimulus with a clocked, restartable, synthesizable checker.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before comparison. 0 is treated as 1.
- `N_CHECK`, default 4: number of output pairs compared (or, and, not1, not2).
- `CNT_W`, default 8: width of the failing-vector counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `start` in 1: level-sampled request to begin a run; accepted only in IDLE.
- `dut_out` in N_CHECK: outputs of the gates under test.
- `ref_out` in N_CHECK: outputs of the reference primitive gates, bit-aligned with `dut_out`.
- `in1` out 1: registered stimulus bit A.
- `in2` out 1: registered stimulus bit B.
- `vec_idx` out 2: index of the vector currently applied (0..3).
- `busy` out 1: high from start acceptance until the last compare completes.
- `done` out 1: one-cycle pulse at run end.
- `pass` out 1: high when the last completed run had zero mismatches; held until the next start is accepted.
- `err_pulse` out 1: one-cycle pulse after any failing compare.
- `fail_mask` out N_CHECK: sticky OR of `dut_out ^ ref_out` over the run.
- `fail_count` out CNT_W: number of failing vectors in the run, saturating at all-ones.

## Operation
- States are IDLE, SETTLE, COMPARE and DONE.
- Vector table, indexed by `vec_idx` and giving (`in1`, `in2`):
  - 0 = (0,0)
  - 1 = (1,0)
  - 2 = (1,1)
  - 3 = (0,1)
  - Only one input toggles per step.
- IDLE with `start`=1:
  - Load vector 0 onto `in1`/`in2`.
  - Clear `fail_mask`, `fail_count` and `pass`.
  - Set `busy`=1 and go to SETTLE.
- SETTLE: the settle counter runs for SETTLE_CYCLES cycles, then the state goes to COMPARE.
- COMPARE, one cycle:
  - mismatch = bitwise case-inequality of `dut_out` vs `ref_out`. X or Z on either side counts as a mismatch.
  - At the exiting edge, `fail_mask` |= mismatch.
  - If any mismatch bit is set, `fail_count` increments (saturating) and `err_pulse`=1 for the next cycle.
  - If `vec_idx`<3: increment `vec_idx`, load the next vector and return to SETTLE.
  - If `vec_idx`=3: go to DONE.
- DONE, one cycle:
  - `done`=1, `busy`=0.
  - `pass` = (`fail_mask`==0), using the value that includes the final compare.
  - Next state is IDLE; `in1`/`in2` return to 0 and `vec_idx` to 0.
- `start` is ignored in SETTLE, COMPARE and DONE. There is no queuing.

## Timing
- Reset value of every output is 0: `in1`, `in2`, `vec_idx`, `busy`, `done`, `pass`, `err_pulse`, `fail_mask`, `fail_count`.
- `rst_n` low forces the reset values immediately, independent of `clk`, from any state. The run is abandoned and no `done` is issued.
- Deassertion is synchronous-released; the first accepted `start` comes at an edge after `rst_n` has been high for one cycle.
- Call the start-accepting edge E0:
  - Vector k is applied from edge E0 + k·(S+1), where S = max(SETTLE_CYCLES,1).
  - The vector is compared during that window's last cycle.
  - `done` is high in the cycle beginning at E0 + 4·(S+1). For the default S=2 that is 12 cycles after E0.
- `err_pulse` for vector k coincides with vector k+1 being applied. For k=3 it coincides with `done`.
- All outputs are registered. There is no combinational path from `dut_out`/`ref_out` to any output.
- `fail_count` at all-ones holds; it never wraps.
- `start` held high continuously gives back-to-back runs with exactly one IDLE cycle between `done` and the next E0.

## Test plan
- **Reset:** drive `rst_n`=0 with random inputs → all outputs 0. Release, hold `start`=0 for 10 cycles → outputs stay 0.
- **Clean run:** tie `dut_out`=`ref_out` as real or/and/not gates, pulse `start` → (`in1`,`in2`) = 00,10,11,01 with each held 3 cycles, `done` 12 cycles after E0, `pass`=1, `fail_mask`=0, `fail_count`=0, no `err_pulse`.
- **Stuck AND:** force `dut_out[1]`=0 → mismatch only at vector 2 → `fail_mask`=4'b0010, `fail_count`=1, `pass`=0, exactly one `err_pulse` (cycle 9 after E0).
- **Start handling:** pulse `start` mid-run → ignored, timing unchanged. `start` after `done` → counters and mask cleared at the new E0, `pass` cleared until the new `done`.
- **Reset mid-run:** assert `rst_n`=0 during SETTLE of vector 1 → outputs 0 asynchronously, no `done`. A subsequent clean run passes.
- **Saturation:** CNT_W=2, invert all `dut_out` → `fail_count`=3 (saturated, not 0), `fail_mask`=4'b1111, 4 `err_pulse`s.

Source files
------------

// File: rtl/gate_check_sequencer.sv
// Clocked stimulus/compare sequencer for the NAND-built gate cells: walks (in1,in2)
// through four Gray-ordered vectors and checks N_CHECK gate outputs against reference gates.
module gate_check_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned N_CHECK       = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_CHECK-1:0] dut_out,
    input  logic [N_CHECK-1:0] ref_out,
    output logic               in1,
    output logic               in2,
    output logic [1:0]         vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               err_pulse,
    output logic [N_CHECK-1:0] fail_mask,
    output logic [CNT_W-1:0]   fail_count
);

    // A settle window of zero still needs one cycle for the vector to propagate.
    localparam int unsigned S_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SET_W = (S_EFF > 1) ? $clog2(S_EFF) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(S_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       VEC_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;
    logic               r_in1, w_in1_nxt;
    logic               r_in2, w_in2_nxt;
    logic [1:0]         r_vec_idx, w_vec_idx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_err_pulse, w_err_pulse_nxt;
    logic [N_CHECK-1:0] r_fail_mask, w_fail_mask_nxt;
    logic [CNT_W-1:0]   r_fail_count, w_fail_count_nxt;

    logic [N_CHECK-1:0] w_mismatch;
    logic [N_CHECK-1:0] w_mask_acc;
    logic [1:0]         w_vec_step;

    // Gray-ordered vector table: returns {in1, in2} for index k.
    function automatic logic [1:0] vec_bits(input logic [1:0] k);
        return {k[0] ^ k[1], k[1]};
    endfunction

    // Case inequality so that X/Z on either side is reported as a mismatch.
    always_comb begin
        w_mismatch = '0;
        for (int unsigned i = 0; i < N_CHECK; i++) begin
            w_mismatch[i] = (dut_out[i] !== ref_out[i]);
        end
    end

    assign w_mask_acc = r_fail_mask | w_mismatch;
    assign w_vec_step = r_vec_idx + 2'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_in1_nxt        = r_in1;
        w_in2_nxt        = r_in2;
        w_vec_idx_nxt    = r_vec_idx;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_pass_nxt       = r_pass;
        w_err_pulse_nxt  = 1'b0;
        w_fail_mask_nxt  = r_fail_mask;
        w_fail_count_nxt = r_fail_count;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt              = ST_SETTLE;
                    w_settle_cnt_nxt         = '0;
                    w_vec_idx_nxt            = 2'd0;
                    {w_in1_nxt, w_in2_nxt}   = vec_bits(2'd0);
                    w_busy_nxt               = 1'b1;
                    w_pass_nxt               = 1'b0;
                    w_fail_mask_nxt          = '0;
                    w_fail_count_nxt         = '0;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt == SET_LAST) begin
                    w_state_nxt = ST_COMPARE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SET_W'(1);
                end
            end

            ST_COMPARE: begin
                w_fail_mask_nxt = w_mask_acc;
                if (|w_mismatch) begin
                    w_err_pulse_nxt = 1'b1;
                    if (r_fail_count != CNT_MAX) begin
                        w_fail_count_nxt = r_fail_count + CNT_W'(1);
                    end
                end
                if (r_vec_idx != VEC_LAST) begin
                    w_state_nxt            = ST_SETTLE;
                    w_settle_cnt_nxt       = '0;
                    w_vec_idx_nxt          = w_vec_step;
                    {w_in1_nxt, w_in2_nxt} = vec_bits(w_vec_step);
                end else begin
                    // Verdict must include the compare happening on this same edge.
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_pass_nxt  = (w_mask_acc == '0);
                end
            end

            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_vec_idx_nxt = 2'd0;
                w_in1_nxt     = 1'b0;
                w_in2_nxt     = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_in1        <= 1'b0;
            r_in2        <= 1'b0;
            r_vec_idx    <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_fail_mask  <= '0;
            r_fail_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_in1        <= w_in1_nxt;
            r_in2        <= w_in2_nxt;
            r_vec_idx    <= w_vec_idx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err_pulse  <= w_err_pulse_nxt;
            r_fail_mask  <= w_fail_mask_nxt;
            r_fail_count <= w_fail_count_nxt;
        end
    end

    assign in1        = r_in1;
    assign in2        = r_in2;
    assign vec_idx    = r_vec_idx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_pulse  = r_err_pulse;
    assign fail_mask  = r_fail_mask;
    assign fail_count = r_fail_count;

endmodule
